// File: rtl/delay_prog_pkg.sv
// Shared definitions for the programmable edge-delay cell: edge-mode encodings
// and the per-channel state type.
package delay_prog_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_BYP  = 2'b11;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_e;

endpackage

// File: rtl/delay_prog_ch.sv
// One delay channel: registered input sample, edge classifier and a counting FSM
// that forwards an edge only after it has held for the latched delay.
module delay_prog_ch
  import delay_prog_pkg::*;
#(
  parameter int   CNTW    = 8,
  parameter logic RST_VAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            CELSUB,
  input  logic            i,
  input  logic [1:0]      mode,
  input  logic [CNTW-1:0] dly,
  output logic            o,
  output logic            busy
);

  logic            i_q;
  logic            o_q;
  logic            busy_q;
  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic [CNTW-1:0] dly_l_q;
  logic            delayed;
  logic            immediate;
  logic            unused_pins;

  // Supply pins exist only to keep the symbol compatible with the fixed cell.
  assign unused_pins = CELV ^ CELG ^ CELSUB;

  assign o     = o_q;
  assign busy  = busy_q;
  assign cnt_d = cnt_q + 1'b1;

  always_comb begin
    delayed   = 1'b0;
    immediate = 1'b0;
    unique case (mode)
      MODE_RISE: delayed = i_q & ~o_q;
      MODE_FALL: delayed = ~i_q & o_q;
      MODE_BOTH: delayed = i_q ^ o_q;
      default:   delayed = 1'b0;
    endcase
    immediate = ((i_q ^ o_q) & ~delayed) | (mode == MODE_BYP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q     <= RST_VAL;
      o_q     <= RST_VAL;
      busy_q  <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
      dly_l_q <= '0;
    end else begin
      i_q <= i;
      unique case (state_q)
        STABLE: begin
          if (i_q != o_q) begin
            if (immediate) begin
              o_q <= i_q;
            end else begin
              state_q <= COUNT;
              cnt_q   <= '0;
              dly_l_q <= dly;
              busy_q  <= 1'b1;
            end
          end
        end
        COUNT: begin
          // A level that returns before the count expires is dropped as a glitch.
          if (i_q == o_q) begin
            state_q <= STABLE;
            busy_q  <= 1'b0;
          end else if (immediate || cnt_q == dly_l_q) begin
            o_q     <= i_q;
            state_q <= STABLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= STABLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/delay_prog.sv
// NCH independent programmable edge-delay channels with per-channel mode and
// delay count; each channel is a delay_prog_ch instance.
module delay_prog
  import delay_prog_pkg::*;
#(
  parameter int   NCH     = 2,
  parameter int   CNTW    = 8,
  parameter logic RST_VAL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CELV,
  input  logic                CELG,
  input  logic                CELSUB,
  input  logic [NCH-1:0]      i,
  input  logic [2*NCH-1:0]    mode,
  input  logic [CNTW*NCH-1:0] dly,
  output logic [NCH-1:0]      o,
  output logic [NCH-1:0]      busy
);

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    delay_prog_ch #(
      .CNTW   (CNTW),
      .RST_VAL(RST_VAL)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .CELV  (CELV),
      .CELG  (CELG),
      .CELSUB(CELSUB),
      .i     (i[n]),
      .mode  (mode[2*n+1:2*n]),
      .dly   (dly[CNTW*n+CNTW-1:CNTW*n]),
      .o     (o[n]),
      .busy  (busy[n])
    );
  end

endmodule
